rc4_phase_sequencer: RTL

- Top-level controller for the shared 256x8 S-memory in the RC4 decryption core.
- Sequences the three phases in order: init (S[i]=i), shuffle (key-scheduling swap loop) and decrypt (PRGA + message XOR).
- Issues one start pulse per phase, waits for each phase's done, and grants the single memory port to exactly one phase engine at a time.
- Reports overall status to the top level.

---
 rtl/rc4_phase_sequencer.sv | 225 ++++++++++++++++++++++
 1 files changed

// File: rtl/rc4_phase_sequencer.sv
// RC4 phase sequencer: init -> shuffle -> decrypt, owns the S-memory port grant.
// Define KEY_SWEEP_EN to retry failed decrypts with successive keys up to KEY_MAX.
module rc4_phase_sequencer #(
  parameter int unsigned      KEY_W          = 24,
  parameter int unsigned      TIMEOUT_CYCLES = 4096,
  parameter logic [KEY_W-1:0] KEY_MAX        = 24'h3FFFFF
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic [KEY_W-1:0] key_in,
  input  logic             init_done,
  input  logic             shuf_done,
  input  logic             dec_done,
  input  logic             dec_ok,
  input  logic [7:0]       init_addr,
  input  logic [7:0]       shuf_addr,
  input  logic [7:0]       dec_addr,
  input  logic [7:0]       init_wdata,
  input  logic [7:0]       shuf_wdata,
  input  logic [7:0]       dec_wdata,
  input  logic             init_wen,
  input  logic             shuf_wen,
  input  logic             dec_wen,
  output logic             init_start,
  output logic             shuf_start,
  output logic             dec_start,
  output logic [KEY_W-1:0] active_key,
  output logic [7:0]       mem_addr,
  output logic [7:0]       mem_wdata,
  output logic             mem_wen,
  output logic [1:0]       phase,
  output logic             busy,
  output logic             done,
  output logic             fail
);

  localparam int unsigned WD_W =
    (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [WD_W-1:0] WD_LAST =
    WD_W'(TIMEOUT_CYCLES - 1);

  localparam logic [1:0] PH_NONE = 2'd0;
  localparam logic [1:0] PH_INIT = 2'd1;
  localparam logic [1:0] PH_SHUF = 2'd2;
  localparam logic [1:0] PH_DEC  = 2'd3;

  typedef enum logic [2:0] {
    S_IDLE,
    S_INIT,
    S_SHUF,
    S_DEC,
    S_DONE,
    S_FAIL
  } state_e;

  state_e           state_q, state_d;
  logic [KEY_W-1:0] key_q, key_d;
  logic [WD_W-1:0]  wd_q, wd_d;
  logic             init_start_q, init_start_d;
  logic             shuf_start_q, shuf_start_d;
  logic             dec_start_q, dec_start_d;
  logic [1:0]       phase_q, phase_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             fail_q, fail_d;

  logic ph_done;
  logic wd_hit;

`ifndef KEY_SWEEP_EN
  logic unused_key_max;
  assign unused_key_max = ^KEY_MAX;
`endif

  // A done flag seen alongside its own start pulse is stale.
  always_comb begin
    ph_done = 1'b0;
    unique case (state_q)
      S_INIT:  ph_done = init_done & ~init_start_q;
      S_SHUF:  ph_done = shuf_done & ~shuf_start_q;
      S_DEC:   ph_done = dec_done & ~dec_start_q;
      default: ph_done = 1'b0;
    endcase
  end

  assign wd_hit = (wd_q == WD_LAST);

  always_comb begin
    state_d      = state_q;
    key_d        = key_q;
    wd_d         = wd_q;
    done_d       = done_q;
    fail_d       = fail_q;
    init_start_d = 1'b0;
    shuf_start_d = 1'b0;
    dec_start_d  = 1'b0;
    unique case (state_q)
      S_IDLE, S_DONE, S_FAIL: begin
        if (start) begin
          key_d        = key_in;
          wd_d         = '0;
          done_d       = 1'b0;
          fail_d       = 1'b0;
          init_start_d = 1'b1;
          state_d      = S_INIT;
        end
      end
      S_INIT, S_SHUF, S_DEC: begin
        if (ph_done) begin
          wd_d = '0;
          unique case (state_q)
            S_INIT: begin
              shuf_start_d = 1'b1;
              state_d      = S_SHUF;
            end
            S_SHUF: begin
              dec_start_d = 1'b1;
              state_d     = S_DEC;
            end
            default: begin
              if (dec_ok) begin
                done_d  = 1'b1;
                state_d = S_DONE;
              end
`ifdef KEY_SWEEP_EN
              else if (key_q < KEY_MAX) begin
                key_d        = key_q + KEY_W'(1);
                init_start_d = 1'b1;
                state_d      = S_INIT;
              end
`endif
              else begin
                fail_d  = 1'b1;
                state_d = S_FAIL;
              end
            end
          endcase
        end else if (wd_hit) begin
          fail_d  = 1'b1;
          state_d = S_FAIL;
        end else begin
          wd_d = wd_q + WD_W'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    phase_d = PH_NONE;
    unique case (state_d)
      S_INIT:  phase_d = PH_INIT;
      S_SHUF:  phase_d = PH_SHUF;
      S_DEC:   phase_d = PH_DEC;
      default: phase_d = PH_NONE;
    endcase
    busy_d = (phase_d != PH_NONE);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= S_IDLE;
      key_q        <= '0;
      wd_q         <= '0;
      init_start_q <= 1'b0;
      shuf_start_q <= 1'b0;
      dec_start_q  <= 1'b0;
      phase_q      <= PH_NONE;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      fail_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      key_q        <= key_d;
      wd_q         <= wd_d;
      init_start_q <= init_start_d;
      shuf_start_q <= shuf_start_d;
      dec_start_q  <= dec_start_d;
      phase_q      <= phase_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      fail_q       <= fail_d;
    end
  end

  // Grant follows the registered phase so it cannot glitch on done inputs.
  always_comb begin
    mem_addr  = 8'h00;
    mem_wdata = 8'h00;
    mem_wen   = 1'b0;
    unique case (phase_q)
      PH_INIT: begin
        mem_addr  = init_addr;
        mem_wdata = init_wdata;
        mem_wen   = init_wen;
      end
      PH_SHUF: begin
        mem_addr  = shuf_addr;
        mem_wdata = shuf_wdata;
        mem_wen   = shuf_wen;
      end
      PH_DEC: begin
        mem_addr  = dec_addr;
        mem_wdata = dec_wdata;
        mem_wen   = dec_wen;
      end
      default: begin
        mem_addr  = 8'h00;
        mem_wdata = 8'h00;
        mem_wen   = 1'b0;
      end
    endcase
  end

  assign init_start = init_start_q;
  assign shuf_start = shuf_start_q;
  assign dec_start  = dec_start_q;
  assign active_key = key_q;
  assign phase      = phase_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign fail       = fail_q;

endmodule
